// File: rtl/debounce_pkg.sv
// Shared types and default constants for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int unsigned DB_CNT_W       = 21;
  localparam int unsigned DB_SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_explicit_fsm_sync_ff.sv
// N-stage input synchronizer, asynchronous active-high reset to 0.
module sync_ff #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/debounce_explicit_fsm.sv
// Four-state switch debouncer: clean level plus one-cycle pulse per accepted press.
module debounce_explicit_fsm
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W       = DB_CNT_W,
  parameter int unsigned SYNC_STAGES = DB_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s;
  logic             tick;

  sync_ff #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw),
    .q   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and Mealy press pulse; each WAIT exits at cnt=0 so no wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tick      = 1'b0;
    case (state)
      ZERO: begin
        if (s) begin
          state_nxt = WAIT1;
          cnt_nxt   = CNT_MAX;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_nxt = ZERO;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = ONE;
          tick      = 1'b1;
        end
      end
      ONE: begin
        if (!s) begin
          state_nxt = WAIT0;
          cnt_nxt   = CNT_MAX;
        end
      end
      WAIT0: begin
        if (s) begin
          state_nxt = ONE;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = ZERO;
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign db_level = (state == ONE) || (state == WAIT0);
  assign db_tick  = tick;

endmodule

// File: tb/tb_debounce_explicit_fsm.sv
// Directed self-checking bench for debounce_explicit_fsm with CNT_W=4, SYNC_STAGES=2.
module tb_debounce_explicit_fsm;

  logic clk = 1'b0;
  logic rst;
  logic sw;
  logic db_level;
  logic db_tick;

  int checks = 0;
  int errors = 0;
  int tick_total = 0;
  int tick_mark = 0;

  always #5 clk = ~clk;

  debounce_explicit_fsm #(.CNT_W(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  task automatic check_bit(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input int obs, input int exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Step n edges with sw held; k counts edges since sw was last set (edge k = E_k).
  task automatic run_check(input int n, input int tick_at, input int level_from,
                           input logic lvl_before, input logic lvl_after, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (db_tick === 1'b1) tick_total++;
      check_bit(db_tick, 1'(k == tick_at), $sformatf("%s_tick_e%0d", tag, k));
      check_bit(db_level, (k >= level_from) ? lvl_after : lvl_before,
                $sformatf("%s_level_e%0d", tag, k));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with sw high
    rst = 1'b1;
    sw  = 1'b1;
    #1;
    check_bit(db_level, 1'b0, "rst_level_t0");
    check_bit(db_tick, 1'b0, "rst_tick_t0");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_bit(db_level, 1'b0, "rst_level_hold");
      check_bit(db_tick, 1'b0, "rst_tick_hold");
    end
    rst = 1'b0;

    // Clean press from reset release: tick after E17, level at E18
    run_check(22, 17, 18, 1'b0, 1'b1, "press");

    // Clean release
    sw = 1'b0;
    run_check(22, -1, 18, 1'b1, 1'b0, "release");

    // Bounce on press
    tick_mark = tick_total;
    sw = 1'b1;
    run_check(10, -1, 1000, 1'b0, 1'b0, "bpress_burst");
    sw = 1'b0;
    run_check(1, -1, 1000, 1'b0, 1'b0, "bpress_gap");
    sw = 1'b1;
    run_check(22, 17, 18, 1'b0, 1'b1, "bpress_final");
    check_int(tick_total - tick_mark, 1, "bpress_tick_count");

    // Release with bounce
    sw = 1'b0;
    run_check(5, -1, 1000, 1'b1, 1'b1, "brel_low");
    sw = 1'b1;
    run_check(2, -1, 1000, 1'b1, 1'b1, "brel_high");
    sw = 1'b0;
    run_check(22, -1, 18, 1'b1, 1'b0, "brel_final");

    // Reset mid-WAIT1: cnt is 7 after E10
    sw = 1'b1;
    run_check(11, -1, 1000, 1'b0, 1'b0, "mid_wait");
    rst = 1'b1;
    #1;
    check_bit(db_level, 1'b0, "midrst_level_assert");
    check_bit(db_tick, 1'b0, "midrst_tick_assert");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (db_tick === 1'b1) tick_total++;
      check_bit(db_level, 1'b0, "midrst_level_hold");
      check_bit(db_tick, 1'b0, "midrst_tick_hold");
    end
    rst = 1'b0;
    run_check(22, 17, 18, 1'b0, 1'b1, "midrst_restart");

    // Back to ZERO, then three repeated presses
    sw = 1'b0;
    run_check(22, -1, 18, 1'b1, 1'b0, "pre_rep");
    tick_mark = tick_total;
    for (int p = 0; p < 3; p++) begin
      sw = 1'b1;
      run_check(30, 17, 18, 1'b0, 1'b1, $sformatf("rep%0d_hi", p));
      sw = 1'b0;
      run_check(30, -1, 18, 1'b1, 1'b0, $sformatf("rep%0d_lo", p));
    end
    check_int(tick_total - tick_mark, 3, "rep_tick_count");
    check_int(tick_total, 6, "total_tick_count");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
